// File: rtl/axi_rd_responder_if.sv
// AXI4 read-address and read-data channel bundle for axi_rd_responder.
// The master modport is the requesting engine; the slave modport is the responder.
interface axi_rd_responder_if #(
    parameter int unsigned ADDR_WIDTH = 33,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned LEN_WIDTH  = 8
) ();
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [ID_WIDTH-1:0]   ARID;
    logic [LEN_WIDTH-1:0]  ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  RVALID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  RLAST;
    logic [ID_WIDTH-1:0]   RID;
    logic [1:0]            RRESP;
    logic                  RREADY;

    modport master (
        output ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, RREADY,
        input  ARREADY, RVALID, RDATA, RLAST, RID, RRESP
    );

    modport slave (
        input  ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, RREADY,
        output ARREADY, RVALID, RDATA, RLAST, RID, RRESP
    );
endinterface

// File: rtl/axi_rd_responder.sv
// AXI4 read responder backed by an internal word memory with a backdoor preload port.
// One outstanding burst, programmable first-beat latency, range checks and forced SLVERR.
module axi_rd_responder #(
    parameter int unsigned ADDR_WIDTH = 33,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    axi_rd_responder_if.slave            s_axi,
    input  logic                         err_inject,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic                         busy,
    output logic [15:0]                  txn_count
);
    localparam int unsigned OFF_W  = $clog2(DATA_WIDTH / 8);
    localparam int unsigned WIDX_W = ADDR_WIDTH - OFF_W;
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int unsigned LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [1:0]            state_q, state_d;
    logic                  arready_q;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [1:0]            rresp_q;
    logic [15:0]           txn_q, txn_d;
    logic [WIDX_W-1:0]     widx_q;
    logic [LEN_WIDTH-1:0]  left_q;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic                  size_bad_q;

    logic                  ar_hs, r_hs;
    logic [WIDX_W-1:0]     ar_widx;
    logic                  ar_size_bad;
    logic                  load, from_ar;
    logic [WIDX_W-1:0]     ld_widx;
    logic                  ld_err, ld_size_bad, ld_in_range, ld_slverr;
    logic [1:0]            ld_burst;
    logic [LEN_WIDTH-1:0]  ld_left;
    logic [DATA_WIDTH-1:0] ld_data;

    // Byte-offset bits inside a beat are deliberately ignored.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^s_axi.ARADDR[OFF_W-1:0];

    assign ar_hs       = s_axi.ARVALID & arready_q;
    assign r_hs        = rvalid_q & s_axi.RREADY;
    assign ar_widx     = s_axi.ARADDR[ADDR_WIDTH-1:OFF_W];
    assign ar_size_bad = (s_axi.ARSIZE != 3'(OFF_W));

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        txn_d    = txn_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        load     = 1'b0;
        from_ar  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    lat_d = LAT_W'(RD_LATENCY - 1);
                    if (RD_LATENCY == 1) begin
                        load    = 1'b1;
                        from_ar = 1'b1;
                        state_d = DATA;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    load    = 1'b1;
                    state_d = DATA;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            DATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        txn_d    = txn_q + 16'd1;
                        state_d  = IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat 0 comes straight off the AR channel only when RD_LATENCY is 1.
    always_comb begin
        ld_widx     = from_ar ? ar_widx : widx_q;
        ld_err      = from_ar ? err_inject : err_q;
        ld_burst    = from_ar ? s_axi.ARBURST : burst_q;
        ld_size_bad = from_ar ? ar_size_bad : size_bad_q;
        ld_left     = from_ar ? s_axi.ARLEN : left_q;
        ld_in_range = ({1'b0, ld_widx} < (WIDX_W + 1)'(MEM_DEPTH));
        ld_slverr   = ld_err | ld_burst[1] | ld_size_bad | ~ld_in_range;
        ld_data     = ld_slverr ? '0 : mem[ld_widx[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rdata_q    <= '0;
            rid_q      <= '0;
            rresp_q    <= RESP_OKAY;
            txn_q      <= '0;
            widx_q     <= '0;
            left_q     <= '0;
            lat_q      <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            size_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= (state_d == IDLE);
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            txn_q     <= txn_d;
            lat_q     <= lat_d;
            if (ar_hs) begin
                rid_q      <= s_axi.ARID;
                burst_q    <= s_axi.ARBURST;
                err_q      <= err_inject;
                size_bad_q <= ar_size_bad;
                widx_q     <= ar_widx;
                left_q     <= s_axi.ARLEN;
            end
            // widx_q/left_q always describe the next beat still to be loaded.
            if (load) begin
                rvalid_q <= 1'b1;
                rdata_q  <= ld_data;
                rresp_q  <= ld_slverr ? RESP_SLVERR : RESP_OKAY;
                rlast_q  <= (ld_left == '0);
                widx_q   <= (ld_burst == BURST_INCR) ? ld_widx + WIDX_W'(1) : ld_widx;
                left_q   <= ld_left - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && ({1'b0, mem_waddr} < (IDX_W + 1)'(MEM_DEPTH))) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RLAST   = rlast_q;
    assign s_axi.RID     = rid_q;
    assign s_axi.RRESP   = rresp_q;
    assign busy          = (state_q != IDLE);
    assign txn_count     = txn_q;
endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: directed vector table, hand-written corner
// sequences and randomized bursts checked against a behavioural memory model.
module tb_axi_rd_responder;
    localparam int unsigned AW    = 33;
    localparam int unsigned DW    = 256;
    localparam int unsigned IW    = 6;
    localparam int unsigned LW    = 8;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam int          NV    = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          err_inject = 1'b0;
    logic          mem_we = 1'b0;
    logic [9:0]    mem_waddr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          busy;
    logic [15:0]   txn_count;

    axi_rd_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

    axi_rd_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW),
        .MEM_DEPTH(DEPTH), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .resetn(resetn), .s_axi(bus), .err_inject(err_inject),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0]          addr;
        logic [5:0]           id;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 err;
        int                   mode;
        logic [7:0]           resp;
        logic [3:0][DW-1:0]   data;
    } vec_t;

    vec_t          tbl [NV];
    int            checks = 0;
    int            failures = 0;
    int            exp_txn = 0;
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] got_data [256];
    logic [1:0]    got_resp [256];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beat i of a burst, straight from the response rules.
    function automatic void model_beat(input longint unsigned w0, input int i,
                                       input logic [1:0] burst, input logic [2:0] size,
                                       input logic err, output logic [DW-1:0] d,
                                       output logic [1:0] r);
        longint unsigned w;
        w = (burst == 2'b00) ? w0 : w0 + longint'(i);
        d = '0;
        r = 2'b10;
        if (err) return;
        else if (burst == 2'b10 || burst == 2'b11) return;
        else if (size != 3'd5) return;
        else if (w >= DEPTH) return;
        r = 2'b00;
        d = model_mem[w];
    endfunction

    task automatic bd_write(input int idx, input logic [DW-1:0] d);
        @(negedge clk);
        mem_we = 1'b1;
        mem_waddr = 10'(idx);
        mem_wdata = d;
        model_mem[idx] = d;
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    // Issues one AR and collects all R beats into got_data/got_resp; checks protocol timing.
    task automatic do_read(input logic [32:0] addr, input logic [5:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic err,
                           input int mode);
        int cyc, k, n, tog;
        bit stalled, seen;
        logic rr;
        logic [DW-1:0] pd;
        logic [8:0] pc;
        n = int'(len) + 1;
        @(negedge clk);
        bus.ARADDR = addr; bus.ARID = id; bus.ARLEN = len; bus.ARSIZE = size;
        bus.ARBURST = burst; bus.ARVALID = 1'b1; err_inject = err; bus.RREADY = 1'b0;
        cyc = 0;
        while (!bus.ARREADY && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.ARREADY) begin
            chk("ar_timeout", 0, 1);
            bus.ARVALID = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.ARVALID = 1'b0;
        err_inject = 1'b0;
        chk("arready_drop", bus.ARREADY, 0);
        chk("busy_high", busy, 1);
        cyc = 1; k = 0; tog = 0; stalled = 0; seen = 0; pd = '0; pc = '0;
        while (k < n && cyc < 400) begin
            if (bus.RVALID) begin
                if (!seen) chk("first_latency", cyc - 1, LAT);
                seen = 1;
                if (stalled) begin
                    chk("hold_data", bus.RDATA, pd);
                    chk("hold_ctrl", {bus.RRESP, bus.RLAST, bus.RID}, pc);
                end
                chk("rid", bus.RID, id);
                chk("rlast", bus.RLAST, (k == n - 1));
                got_data[k] = bus.RDATA;
                got_resp[k] = bus.RRESP;
                pd = bus.RDATA;
                pc = {bus.RRESP, bus.RLAST, bus.RID};
                case (mode)
                    0:       rr = 1'b1;
                    1:       rr = (tog % 2 == 0);
                    default: rr = 1'($urandom_range(0, 1));
                endcase
                tog++;
                bus.RREADY = rr;
                if (rr) k++;
                stalled = !rr;
            end else begin
                if (seen) chk("rvalid_gap", bus.RVALID, 1);
                bus.RREADY = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.RREADY = 1'b0;
        if (k < n) begin
            chk("beats_timeout", k, n);
        end else begin
            exp_txn = (exp_txn + 1) % 65536;
            chk("end_rvalid", bus.RVALID, 0);
            chk("end_rlast", bus.RLAST, 0);
            chk("end_busy", busy, 0);
            chk("end_arready", bus.ARREADY, 1);
            chk("txn_count", txn_count, exp_txn);
        end
    endtask

    task automatic set_vec(input int t, input logic [32:0] addr, input logic [5:0] id,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic err, input int mode, input logic [7:0] resp,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        tbl[t].addr = addr; tbl[t].id = id; tbl[t].len = len; tbl[t].size = size;
        tbl[t].burst = burst; tbl[t].err = err; tbl[t].mode = mode; tbl[t].resp = resp;
        tbl[t].data[0] = d0; tbl[t].data[1] = d1; tbl[t].data[2] = d2; tbl[t].data[3] = d3;
    endtask

    task automatic check_model(input string tag, input logic [32:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic err);
        logic [DW-1:0] ed;
        logic [1:0] er;
        for (int i = 0; i <= int'(len); i++) begin
            model_beat(longint'(addr >> 5), i, burst, size, err, ed, er);
            chk($sformatf("%s_data%0d", tag, i), got_data[i], ed);
            chk($sformatf("%s_resp%0d", tag, i), got_resp[i], er);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a5, w, old_d, new_d;
        logic [32:0] raddr;
        logic [7:0] rlen;
        logic [2:0] rsize;
        logic [1:0] rburst;
        logic rerr;
        longint unsigned widx;
        int cyc, r;

        bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARID = '0; bus.ARLEN = '0;
        bus.ARSIZE = '0; bus.ARBURST = '0; bus.RREADY = 1'b0;
        a5 = {32{8'hA5}};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_arready", bus.ARREADY, 0);
        chk("rst_rvalid", bus.RVALID, 0);
        chk("rst_rlast", bus.RLAST, 0);
        chk("rst_rdata", bus.RDATA, 0);
        chk("rst_rid", bus.RID, 0);
        chk("rst_rresp", bus.RRESP, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txn", txn_count, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("release_arready", bus.ARREADY, 1);
        chk("release_busy", busy, 0);

        // Preload every word so the model and memory agree everywhere
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int j = 0; j < 8; j++) w[32*j +: 32] = $urandom();
            mem_we = 1'b1;
            mem_waddr = 10'(i);
            mem_wdata = w;
            model_mem[i] = w;
            @(negedge clk);
        end
        mem_we = 1'b0;
        bd_write(5, a5);
        for (int i = 0; i < 4; i++) bd_write(8 + i, DW'(i + 1));
        bd_write(1022, DW'(32'hC0DE0));
        bd_write(1023, DW'(32'hC0DE1));

        set_vec(0, 33'hA0, 6'h3, 8'd0, 3'd5, 2'b00, 1'b0, 0, 8'h00, a5, '0, '0, '0);
        set_vec(1, 33'h100, 6'h7, 8'd3, 3'd5, 2'b01, 1'b0, 1, 8'h00,
                DW'(1), DW'(2), DW'(3), DW'(4));
        set_vec(2, 33'h7FC0, 6'h1, 8'd3, 3'd5, 2'b01, 1'b0, 0, 8'b10_10_00_00,
                DW'(32'hC0DE0), DW'(32'hC0DE1), '0, '0);
        set_vec(3, 33'hA0, 6'h2, 8'd0, 3'd5, 2'b00, 1'b1, 0, 8'h02, '0, '0, '0, '0);
        set_vec(4, 33'hA0, 6'h2, 8'd0, 3'd5, 2'b00, 1'b0, 0, 8'h00, a5, '0, '0, '0);
        set_vec(5, 33'h100, 6'h4, 8'd1, 3'd5, 2'b10, 1'b0, 0, 8'b00_00_10_10, '0, '0, '0, '0);
        set_vec(6, 33'h100, 6'h5, 8'd0, 3'd4, 2'b01, 1'b0, 0, 8'h02, '0, '0, '0, '0);
        set_vec(7, 33'h11F, 6'h3F, 8'd2, 3'd5, 2'b00, 1'b0, 1, 8'h00,
                DW'(1), DW'(1), DW'(1), '0);

        for (int t = 0; t < NV; t++) begin
            do_read(tbl[t].addr, tbl[t].id, tbl[t].len, tbl[t].size, tbl[t].burst,
                    tbl[t].err, tbl[t].mode);
            for (int i = 0; i <= int'(tbl[t].len); i++) begin
                chk($sformatf("vec%0d_data%0d", t, i), got_data[i], tbl[t].data[i]);
                chk($sformatf("vec%0d_resp%0d", t, i), got_resp[i], tbl[t].resp[2*i +: 2]);
            end
        end

        // Backdoor write landing on the same edge as the beat load returns the old word
        old_d = model_mem[20];
        new_d = ~old_d;
        @(negedge clk);
        chk("bdw_arready", bus.ARREADY, 1);
        bus.ARADDR = 33'h280; bus.ARID = 6'h11; bus.ARLEN = 8'd0; bus.ARSIZE = 3'd5;
        bus.ARBURST = 2'b00; bus.ARVALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ARVALID = 1'b0;
        @(negedge clk);
        mem_we = 1'b1; mem_waddr = 10'd20; mem_wdata = new_d;
        @(negedge clk);
        mem_we = 1'b0;
        model_mem[20] = new_d;
        chk("bdw_rvalid", bus.RVALID, 1);
        chk("bdw_old_data", bus.RDATA, old_d);
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
        exp_txn++;
        chk("bdw_done", bus.RVALID, 0);
        chk("bdw_txn", txn_count, exp_txn);
        do_read(33'h280, 6'h12, 8'd0, 3'd5, 2'b00, 1'b0, 0);
        chk("bdw_new_data", got_data[0], new_d);

        // Synchronous reset in the middle of a len-7 burst
        @(negedge clk);
        bus.ARADDR = 33'h100; bus.ARID = 6'h9; bus.ARLEN = 8'd7; bus.ARSIZE = 3'd5;
        bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ARVALID = 1'b0;
        bus.RREADY = 1'b1;
        cyc = 0;
        while (!bus.RVALID && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_beat1", bus.RDATA, model_mem[8]);
        @(negedge clk);
        chk("mid_beat2", bus.RDATA, model_mem[9]);
        resetn = 1'b0;
        bus.RREADY = 1'b0;
        @(negedge clk);
        exp_txn = 0;
        chk("mid_rvalid", bus.RVALID, 0);
        chk("mid_rlast", bus.RLAST, 0);
        chk("mid_rdata", bus.RDATA, 0);
        chk("mid_busy", busy, 0);
        chk("mid_arready", bus.ARREADY, 0);
        chk("mid_txn", txn_count, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("mid_release_arready", bus.ARREADY, 1);
        do_read(33'h100, 6'h2A, 8'd3, 3'd5, 2'b01, 1'b0, 0);
        check_model("after_rst", 33'h100, 8'd3, 3'd5, 2'b01, 1'b0);

        // Randomized bursts against the model
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 8; j++) w[32*j +: 32] = $urandom();
                bd_write(int'($urandom_range(0, DEPTH - 1)), w);
            end
            r = int'($urandom_range(0, 9));
            if (r < 7) widx = longint'($urandom_range(0, DEPTH - 1));
            else if (r < 9) widx = longint'(DEPTH - 4 + $urandom_range(0, 5));
            else widx = longint'($urandom_range(DEPTH, 32'h07FF_FFFF));
            raddr = {28'(widx), 5'($urandom_range(0, 31))};
            rlen = 8'($urandom_range(0, 15));
            r = int'($urandom_range(0, 9));
            rburst = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : 2'($urandom_range(2, 3));
            rsize = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd5;
            rerr = ($urandom_range(0, 9) == 0);
            do_read(raddr, 6'($urandom()), rlen, rsize, rburst, rerr,
                    int'($urandom_range(0, 2)));
            check_model("rnd", raddr, rlen, rsize, rburst, rerr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
- AXI4 read-channel slave (responder) backed by an internal word memory. It answers AR requests with R beats.
- Serves as the far end for the read engine in simulation and in loopback bring-up, in place of HBM/DDR4.
- Supports FIXED/INCR bursts, a programmable first-beat latency, per-beat range checking and forced-error injection, so the engine's retry path can be exercised.
- A backdoor write port preloads memory contents.

Parameters:
- ADDR_WIDTH, 33, byte address width
- DATA_WIDTH, 256, data bus width; 256 or 512 only
- ID_WIDTH, 6, AXI ID width
- LEN_WIDTH, 8, ARLEN width
- MEM_DEPTH, 1024, number of DATA_WIDTH-bit words in the internal memory
- RD_LATENCY, 2, cycles from AR handshake edge to first RVALID; minimum 1

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- s_axi_ARVALID  in  1  read address valid
- s_axi_ARREADY  out  1  read address ready
- s_axi_ARADDR  in  ADDR_WIDTH  byte address
- s_axi_ARID  in  ID_WIDTH  transaction ID
- s_axi_ARLEN  in  LEN_WIDTH  beats minus 1
- s_axi_ARSIZE  in  3  beat size
- s_axi_ARBURST  in  2  burst type
- s_axi_RVALID  out  1  read data valid
- s_axi_RDATA  out  DATA_WIDTH  read data
- s_axi_RLAST  out  1  last beat
- s_axi_RID  out  ID_WIDTH  echoed ARID
- s_axi_RRESP  out  2  beat status
- s_axi_RREADY  in  1  master ready
- err_inject  in  1  sampled at AR handshake; forces SLVERR on every beat of that burst
- mem_we  in  1  backdoor write enable
- mem_waddr  in  clog2(MEM_DEPTH)  backdoor word index
- mem_wdata  in  DATA_WIDTH  backdoor write data
- busy  out  1  high whenever the FSM is not in IDLE
- txn_count  out  16  count of completed bursts; wraps at 16'hFFFF→0

Behaviour:
- Reset values:
  - ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RID=0, RRESP=00, busy=0, txn_count=0.
  - FSM resets to IDLE; memory contents are not cleared.
  - ARREADY rises 1 cycle after reset release.
- FSM states: IDLE, WAIT, DATA.
- IDLE:
  - ARREADY=1.
  - On ARVALID&ARREADY: latch ARID, ARLEN, ARBURST, err_inject.
  - Word index = ARADDR >> log2(DATA_WIDTH/8); low address bits ignored.
  - Beat counter loads ARLEN and latency counter loads RD_LATENCY-1. ARREADY=0 next cycle.
  - If RD_LATENCY=1, go straight to DATA with beat 0 loaded; otherwise go to WAIT.
- WAIT:
  - Decrement the latency counter.
  - At 0, load beat 0 into the R registers, set RVALID=1 and enter DATA.
  - First RVALID is high exactly RD_LATENCY cycles after the handshake edge.
- DATA:
  - RVALID, RDATA, RRESP, RLAST and RID are held stable until RVALID&RREADY.
  - On a handshake that is not the last beat: the next beat is loaded in the same edge, RVALID stays 1. Full throughput is one beat per cycle while RREADY=1.
  - On a handshake with RLAST=1: RVALID=0, RLAST=0, txn_count+1, return to IDLE. ARREADY=1 the following cycle, so there is a 1-cycle bubble between bursts.
  - RLAST=1 only on the beat where the beat counter reaches 0. ARLEN=0 gives a single beat with RLAST=1.
- Address progression:
  - FIXED (00): word index is constant for all beats.
  - INCR (01): word index +1 per beat, using full-width arithmetic with no wrap; 4 KB boundary not checked.
- Error rules, evaluated per beat, in priority order:
  1. Latched err_inject=1 → SLVERR (10).
  2. ARBURST is 10 (WRAP) or 11 → SLVERR on all beats.
  3. ARSIZE ≠ log2(DATA_WIDTH/8) → SLVERR on all beats.
  4. Word index ≥ MEM_DEPTH → SLVERR for that beat only.
  - Any other case → OKAY (00).
  - On any SLVERR beat RDATA=0. The burst still completes with ARLEN+1 beats and a correct RLAST.
- Memory reads are asynchronous array reads captured into RDATA at beat-load time.
- Backdoor write:
  - Writes on the clk edge with mem_we=1, in any state.
  - A write to the word being loaded on the same edge returns the old data.
  - mem_waddr ≥ MEM_DEPTH is ignored.
- ARVALID while not in IDLE: ARREADY stays 0 and the request is held off. Only one outstanding transaction.
- Reset mid-burst: the synchronous reset aborts the burst. Outputs take their reset values on the next edge with no RLAST emitted, and txn_count=0.

Test Plan:
- Reset, then release → ARREADY=1 one cycle later; all R outputs 0, txn_count=0.
- Preload mem[5]=256'hA5A5…; AR addr 33'hA0, FIXED, len 0, ID 6'h3, RREADY=1 → RVALID 2 cycles after handshake, RDATA=A5A5…, RRESP=00, RLAST=1, RID=3, txn_count=1.
- INCR len 3 from word 8 (mem[8..11]=1,2,3,4), RREADY toggling 1,0,1,0… → beats 1,2,3,4 in order, each held while RREADY=0, RLAST only on beat 4.
- INCR len 3 starting at word MEM_DEPTH-2 → RRESP 00,00,10,10; beats 3 and 4 have RDATA=0.
- err_inject=1 at handshake, single beat → RRESP=10, RDATA=0. Immediate retry with err_inject=0 → RRESP=00 with correct data.
- ARBURST=10 with len 1 → two SLVERR beats, RLAST on the second. Reset asserted during beat 2 of a len-7 burst → RVALID=0 next edge; a fresh read afterwards completes normally.
